// File: rtl/char_motion.sv
// Character motion stage: button synchronisers, game-tick divider, walk logic
// and a ground/rise/fall jump FSM producing the registered character position.
module char_motion #(
    parameter int unsigned TICK_DIV = 1000000,
    parameter int unsigned X_START  = 40,
    parameter int unsigned X_MIN    = 0,
    parameter int unsigned X_MAX    = 620,
    parameter int unsigned STEP     = 2,
    parameter int unsigned GROUND_Y = 400,
    parameter int unsigned JUMP_V   = 12,
    parameter int unsigned GRAVITY  = 1,
    parameter int unsigned MAX_FALL = 8
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    output logic [9:0] char_X,
    output logic [9:0] char_Y,
    output logic       on_ground,
    output logic       facing,
    output logic       tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned POS_W = 10;
    localparam int unsigned EXT_W = 11;
    localparam int unsigned VEL_W = 6;
    localparam int unsigned BTN_W = 3;

    typedef enum logic [1:0] {
        ST_GROUND,
        ST_RISE,
        ST_FALL
    } state_e;

    logic [BTN_W-1:0] sync1_q, sync1_d;
    logic [BTN_W-1:0] sync2_q, sync2_d;
    logic             jump_prev_q, jump_prev_d;
    logic             jump_req_q, jump_req_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic [POS_W-1:0] char_x_q, char_x_d;
    logic [POS_W-1:0] char_y_q, char_y_d;
    logic             facing_q, facing_d;
    logic             on_ground_q, on_ground_d;
    logic [VEL_W-1:0] vy_q, vy_d;
    logic [VEL_W-1:0] vf_q, vf_d;
    state_e           state_q, state_d;

    logic             jump_rise;
    logic             jump_take;
    logic             left_s, right_s;
    logic [EXT_W-1:0] x_ext, x_sum, y_ext;
    logic [VEL_W-1:0] vf_inc, fall_n;

    // Synchronisers, tick divider and single-tick jump request
    always_comb begin
        sync1_d     = {btn_jump, btn_right, btn_left};
        sync2_d     = sync1_q;
        jump_prev_d = sync2_q[2];
        left_s      = sync2_q[0];
        right_s     = sync2_q[1];
        jump_rise   = sync2_q[2] & ~jump_prev_q;
        cnt_d       = (cnt_q == CNT_W'(TICK_DIV - 1)) ? '0 : cnt_q + CNT_W'(1);
        tick_d      = (cnt_d == CNT_W'(TICK_DIV - 1));
        jump_take   = tick_q & (jump_req_q | jump_rise);
        jump_req_d  = tick_q ? 1'b0 : (jump_req_q | jump_rise);
    end

    // Walking with edge clamps; computed one bit wider so nothing wraps
    always_comb begin
        char_x_d = char_x_q;
        facing_d = facing_q;
        x_ext    = {1'b0, char_x_q};
        x_sum    = x_ext + EXT_W'(STEP);
        if (tick_q && left_s && !right_s) begin
            facing_d = 1'b1;
            if (x_ext >= EXT_W'(X_MIN) + EXT_W'(STEP)) begin
                char_x_d = POS_W'(x_ext - EXT_W'(STEP));
            end else begin
                char_x_d = POS_W'(X_MIN);
            end
        end else if (tick_q && right_s && !left_s) begin
            facing_d = 1'b0;
            if (x_sum > EXT_W'(X_MAX)) begin
                char_x_d = POS_W'(X_MAX);
            end else begin
                char_x_d = POS_W'(x_sum);
            end
        end
    end

    // Vertical FSM: next state, Y position and speeds
    always_comb begin
        state_d  = state_q;
        char_y_d = char_y_q;
        vy_d     = vy_q;
        vf_d     = vf_q;
        y_ext    = {1'b0, char_y_q};
        vf_inc   = vf_q + VEL_W'(GRAVITY);
        fall_n   = (vf_inc > VEL_W'(MAX_FALL)) ? VEL_W'(MAX_FALL) : vf_inc;
        if (tick_q) begin
            case (state_q)
                ST_GROUND: begin
                    char_y_d = POS_W'(GROUND_Y);
                    if (jump_take) begin
                        vy_d    = VEL_W'(JUMP_V);
                        state_d = ST_RISE;
                    end
                end
                ST_RISE: begin
                    if (y_ext < EXT_W'(vy_q)) begin
                        char_y_d = '0;
                        vf_d     = '0;
                        state_d  = ST_FALL;
                    end else begin
                        char_y_d = char_y_q - POS_W'(vy_q);
                        if (vy_q <= VEL_W'(GRAVITY)) begin
                            vf_d    = '0;
                            state_d = ST_FALL;
                        end else begin
                            vy_d = vy_q - VEL_W'(GRAVITY);
                        end
                    end
                end
                ST_FALL: begin
                    vf_d = fall_n;
                    if (y_ext + EXT_W'(fall_n) >= EXT_W'(GROUND_Y)) begin
                        char_y_d = POS_W'(GROUND_Y);
                        vf_d     = '0;
                        state_d  = ST_GROUND;
                    end else begin
                        char_y_d = POS_W'(y_ext + EXT_W'(fall_n));
                    end
                end
                default: state_d = ST_GROUND;
            endcase
        end
        on_ground_d = (state_d == ST_GROUND);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            jump_prev_q <= 1'b0;
            jump_req_q  <= 1'b0;
            cnt_q       <= '0;
            tick_q      <= 1'b0;
            char_x_q    <= POS_W'(X_START);
            char_y_q    <= POS_W'(GROUND_Y);
            facing_q    <= 1'b0;
            on_ground_q <= 1'b1;
            vy_q        <= '0;
            vf_q        <= '0;
            state_q     <= ST_GROUND;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            jump_prev_q <= jump_prev_d;
            jump_req_q  <= jump_req_d;
            cnt_q       <= cnt_d;
            tick_q      <= tick_d;
            char_x_q    <= char_x_d;
            char_y_q    <= char_y_d;
            facing_q    <= facing_d;
            on_ground_q <= on_ground_d;
            vy_q        <= vy_d;
            vf_q        <= vf_d;
            state_q     <= state_d;
        end
    end

    assign char_X    = char_x_q;
    assign char_Y    = char_y_q;
    assign on_ground = on_ground_q;
    assign facing    = facing_q;
    assign tick      = tick_q;

endmodule
